// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: lane geometry, lane vector type, pooling FSM
// states and the per-lane two's-complement max helper.
package cnn_pkg;

  localparam int CH = 8;
  localparam int DW = 16;

  typedef logic signed [DW-1:0] lane_t;
  typedef lane_t [CH-1:0]       lane_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pool_state_t;

  // Ties resolve to a, which is a valid max either way.
  function automatic lane_t lane_max(input lane_t a, input lane_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/cnn_lane_max.sv
// Combinational per-lane signed max of two CH-lane vectors
// (lane c at bits [c*DW +: DW]).
module cnn_lane_max #(
  parameter int CH = cnn_pkg::CH,
  parameter int DW = cnn_pkg::DW
) (
  input  logic [CH*DW-1:0] a,
  input  logic [CH*DW-1:0] b,
  output logic [CH*DW-1:0] y
);
  import cnn_pkg::*;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    assign y[c*DW +: DW] = lane_max(a[c*DW +: DW], b[c*DW +: DW]);
  end

endmodule

// File: rtl/layer1_maxpool.sv
// 2x2 stride-2 max pool over a raster-order CH-lane pixel stream, one frame per start.
// Optional build macro LAYER1_POOL_RELU_EN clamps negative input lanes to zero first.
module layer1_maxpool #(
  parameter int IMG_W = 30,
  parameter int IMG_H = 30,
  parameter int CH    = cnn_pkg::CH,
  parameter int DW    = cnn_pkg::DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic [1:0]       dbg_state
);
  import cnn_pkg::*;

  localparam int W      = CH * DW;
  localparam int HALF_W = IMG_W / 2;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);

  // Handshakes: a word moves on any posedge where valid && ready are both high;
  // a producer holds valid and data steady until that edge, ready never waits on valid.
  pool_state_t    state_q, state_d;
  logic [CW-1:0]  col_q;
  logic [RW-1:0]  row_q;
  logic [W-1:0]   pair_q;
  logic [W-1:0]   in_lanes;
  logic [W-1:0]   pair_max;
  logic [W-1:0]   pool_max;
  logic [W-1:0]   line_buf [HALF_W];
  logic [CW-2:0]  buf_idx;
  logic           in_fire, out_fire, col_last, row_last;

`ifdef LAYER1_POOL_RELU_EN
  for (genvar c = 0; c < CH; c++) begin : g_relu
    assign in_lanes[c*DW +: DW] = in_data[c*DW + DW - 1] ? '0 : in_data[c*DW +: DW];
  end
`else
  assign in_lanes = in_data;
`endif

  assign in_ready  = (state_q == RUN) && (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;
  assign col_last  = (col_q == CW'(IMG_W - 1));
  assign row_last  = (row_q == RW'(IMG_H - 1));
  assign buf_idx   = col_q[CW-1:1];

  cnn_lane_max #(.CH(CH), .DW(DW)) u_pair_max (
    .a (pair_q),
    .b (in_lanes),
    .y (pair_max)
  );

  cnn_lane_max #(.CH(CH), .DW(DW)) u_pool_max (
    .a (line_buf[buf_idx]),
    .b (pair_max),
    .y (pool_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (out_fire && out_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q     <= '0;
      row_q     <= '0;
      pair_q    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        col_q <= '0;
        row_q <= '0;
      end else if (in_fire) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (in_fire && !col_q[0]) pair_q <= in_lanes;
      // in_ready already guarantees the output slot is free or draining this edge.
      if (in_fire && col_q[0] && row_q[0]) begin
        out_valid <= 1'b1;
        out_data  <= pool_max;
        out_last  <= row_last && col_last;
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Even rows only park pair maxima; odd rows consume them before they are rewritten.
  always_ff @(posedge clk) begin
    if (in_fire && col_q[0] && !row_q[0]) line_buf[buf_idx] <= pair_max;
  end

endmodule

// File: doc/layer1_maxpool.md
LAYER1_MAXPOOL -- requirements
Module: layer1_maxpool

Interface
REQ-001 SHALL have parameter IMG_W, default 30, meaning input columns per row (even).
REQ-002 SHALL have parameter IMG_H, default 30, meaning input rows per frame (even).
REQ-003 SHALL have parameter CH, default 8, meaning channels per pixel word.
REQ-004 SHALL have parameter DW, default 16, meaning signed bits per channel lane.
REQ-005 SHALL have port clk, input, 1, the single clock; all state rises on posedge clk.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle pulse that begins a frame.
REQ-008 SHALL have port in_valid, input, 1, input word valid.
REQ-009 SHALL have port in_ready, output, 1, input word accepted when in_valid and in_ready are both high.
REQ-010 SHALL have port in_data, input, CH*DW, conv result pixel; lane c occupies bits [c*DW +: DW]; raster order.
REQ-011 SHALL have port out_valid, output, 1, pooled word valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accept.
REQ-013 SHALL have port out_data, output, CH*DW, pooled pixel, same lane layout.
REQ-014 SHALL have port out_last, output, 1, high with the final pooled word of the frame.
REQ-015 SHALL have port done, output, 1, one-cycle pulse on frame completion.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE on the handshake of the out_last word; DONE->IDLE unconditionally after one cycle, with done high only in DONE.
REQ-017 SHALL ignore start in RUN and DONE, and SHALL hold in_ready low in IDLE and DONE.
REQ-018 SHALL keep row counter 0..IMG_H-1 and column counter 0..IMG_W-1, advancing only on input handshakes; column wraps to 0 and increments row.
REQ-019 SHALL register each even-column word, and on the following odd-column word compute the per-lane signed max of the pair.
REQ-020 SHALL, on an even row, store the pair max into line buffer entry col/2 (IMG_W/2 entries of CH*DW bits).
REQ-021 SHALL, on an odd row, output the per-lane signed max of buffer entry col/2 and the pair max, registered, so out_valid rises the cycle after the accepting handshake.
REQ-022 SHALL hold out_data, out_valid and out_last stable while out_valid is high and out_ready is low.
REQ-023 SHALL drive in_ready = RUN and (not out_valid or out_ready); simultaneous output drain and input accept in one cycle SHALL be lossless.
REQ-024 SHALL produce exactly (IMG_W/2)*(IMG_H/2) outputs per frame (225 at defaults), and assert out_last on output index 224 (row 29, col 29 input).
REQ-025 SHALL treat equal lane values as valid max (either operand); comparisons SHALL be two's-complement signed.

Reset
REQ-026 SHALL, on rst low, asynchronously enter IDLE, clear counters and the pair register, and drive in_ready, out_valid, out_last and done to 0 and out_data to 0; line buffer contents are don't-care.
REQ-027 SHALL abandon any partial frame on reset mid-frame; the next frame requires a new start.

Configuration
REQ-028 SHALL, when macro LAYER1_POOL_RELU_EN is defined, clamp each negative input lane to 0 before pooling; when undefined, lanes pass to the max logic unmodified.

Structure
REQ-029 SHALL take CH, DW, lane-vector typedef and per-lane signed-max function from shared package cnn_pkg.
REQ-030 SHALL place the CH-lane signed max in sub-module cnn_lane_max (two vector inputs, one vector output, combinational).

Verification
REQ-031 Bench SHALL feed ramp value (row*30+col) in every lane, out_ready=1 -> output k equals (2*(k/15)+1)*30+2*(k%15)+1, out_last at k=224, done one cycle after.
REQ-032 Bench SHALL feed all lanes 0xFFF0 (-16) except one 0x0005 per window -> output 0x0005; all-0xFFF0 frame -> 0xFFF0 without LAYER1_POOL_RELU_EN, 0x0000 with it.
REQ-033 Bench SHALL hold out_ready low for 5 cycles mid-frame -> in_ready low, out_data stable, no output lost or duplicated (225 total).
REQ-034 Bench SHALL pulse start during RUN -> ignored, frame completes normally with 225 outputs.
REQ-035 Bench SHALL assert rst low after 400 inputs -> all outputs 0 next edge; new start and full frame -> correct 225 outputs.
REQ-036 Bench SHALL randomize in_valid gaps -> output sequence identical to REQ-031 golden.
